// File: rtl/daq_buffer_reader.sv
// rtl/daq_buffer_reader.sv - wrap-around read sweeper for the DAQ event buffer with a credit-managed skid FIFO stream
module daq_buffer_reader #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic              abort,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = ADDR_W + 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1) << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  req_cnt;
    logic [RD_LAT:0]   pipe_v_q, pipe_v_d;
    logic [RD_LAT:0]   pipe_last_q, pipe_last_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              push, pop, flush, issue, issue_last, can_issue;
    logic [7:0]        in_flight, load;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign dout_valid = (occ_q != '0);
    assign dout       = mem_q[rd_ptr_q][DATA_W-1:0];
    assign dout_last  = dout_valid & mem_q[rd_ptr_q][DATA_W];
    assign addrb      = addrb_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        req_cnt = (CNT_W'(word_count) > MAX_CNT) ? MAX_CNT : CNT_W'(word_count);
        push    = pipe_v_q[RD_LAT];
        pop     = dout_valid & dout_ready;
        flush   = abort && (state_q == S_READ || state_q == S_DRAIN);

        // Pipeline stage 0 is the cycle addrb is presented; stage RD_LAT lines up with doutb.
        in_flight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            in_flight = in_flight + 8'(pipe_v_q[i]);
        end
        // A pop this cycle frees a slot, which keeps the stream bubble-free at full rate.
        load      = 8'(occ_q) + in_flight - 8'(pop);
        can_issue = load < 8'(FIFO_DEPTH);

        state_d    = state_q;
        addr_d     = addr_q;
        addrb_d    = addrb_q;
        rem_d      = rem_q;
        issue      = 1'b0;
        issue_last = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_cnt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        issue      = 1'b1;
                        addrb_d    = base_addr;
                        addr_d     = base_addr + ADDR_W'(1);
                        rem_d      = req_cnt - CNT_W'(1);
                        issue_last = (req_cnt == CNT_W'(1));
                        state_d    = issue_last ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if (flush) begin
                    state_d = S_DONE;
                end else if (can_issue) begin
                    issue      = 1'b1;
                    addrb_d    = addr_q;
                    addr_d     = addr_q + ADDR_W'(1);
                    rem_d      = rem_q - CNT_W'(1);
                    issue_last = (rem_q == CNT_W'(1));
                    if (issue_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    state_d = S_DONE;
                end else if (pop && dout_last && in_flight == 8'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pipe_v_d    = {pipe_v_q[RD_LAT-1:0], issue};
        pipe_last_d = {pipe_last_q[RD_LAT-1:0], issue_last};

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            pipe_v_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end

        busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
        done_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            addrb_q     <= '0;
            rem_q       <= '0;
            pipe_v_q    <= '0;
            pipe_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addrb_q     <= addrb_d;
            rem_q       <= rem_d;
            pipe_v_q    <= pipe_v_d;
            pipe_last_q <= pipe_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= {pipe_last_q[RD_LAT], doutb};
        end
    end
endmodule

// File: tb/tb_daq_buffer_reader.sv
// tb/tb_daq_buffer_reader.sv - self-checking bench for daq_buffer_reader
module tb_daq_buffer_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, start, abort, dout_ready;
    logic        dout_valid, dout_last, busy, done;
    logic [14:0] base_addr, addrb;
    logic [15:0] word_count;
    logic [31:0] doutb, dout;

    daq_buffer_reader dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .addrb      (addrb),
        .doutb      (doutb),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return 32'hDA7A_0000 | {17'd0, a};
    endfunction

    // Buffer model: data appears two cycles after the address.
    logic [14:0] rd_a1;
    logic [31:0] rd_d2;
    always @(posedge clk) begin
        rd_a1 <= addrb;
        rd_d2 <= mem_word(rd_a1);
    end
    assign doutb = rd_d2;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc = 0;
    int          last_cyc = -1;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [14:0] wrap_exp [4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Stream monitor: every accepted beat against the expected word queue, and stability under stall.
    always @(negedge clk) begin
        if (resetn) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(dout_valid), 32'd1);
                chk("stall_data", dout, prev_data);
                chk("stall_last", 32'(dout_last), 32'(prev_last));
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got word 0x%0h, expected no beat", dout);
                end else begin
                    chk("beat_data", dout, exp_q[0]);
                    chk("beat_last", 32'(dout_last), 32'(exp_q.size() == 1));
                    void'(exp_q.pop_front());
                end
                acc++;
                got_q.push_back(dout);
                if (dout_last) last_cyc = cyc;
            end
            prev_stall = dout_valid && !dout_ready && !abort;
            prev_data  = dout;
            prev_last  = dout_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [14:0] b, input logic [15:0] n, output int s0);
        int m;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        m = (n > 16'd32768) ? 32768 : int'(n);
        for (int i = 0; i < m; i++) exp_q.push_back(mem_word(b + 15'(i)));
        @(posedge clk);
        #1;
        start = 1'b0;
        s0 = cyc - 1;
    endtask

    task automatic run(input int bound, input bit rnd, output int lowc, output int dcyc);
        lowc = 0;
        dcyc = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
            if (!busy) lowc++;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rnd) dout_ready = 1'($urandom_range(0, 1));
        end
        chk("done_seen", 32'(dcyc >= 0), 32'd1);
    endtask

    initial begin
        int s0, lowc, dcyc, fv, dh;
        wrap_exp[0] = 15'h7FFE;
        wrap_exp[1] = 15'h7FFF;
        wrap_exp[2] = 15'h0000;
        wrap_exp[3] = 15'h0001;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
        base_addr = '0; word_count = '0;
        repeat (3) cyc_adv();
        @(negedge clk);
        chk("rst_addrb", 32'(addrb), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_last", 32'(dout_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        cyc_adv();
        resetn = 1'b1;
        cyc_adv();

        // basic readout and latency
        acc = 0; got_q.delete();
        do_start(15'h0010, 16'd4, s0);
        fv = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (dout_valid) begin
                fv = k;
                break;
            end
        end
        chk("first_valid_latency", fv, 4);
        run(50, 1'b0, lowc, dcyc);
        chk("t1_beats", acc, 4);
        chk("t1_busy_low", lowc, 1);
        chk("t1_done_lag", dcyc - last_cyc, 2);
        chk("t1_word0", got_q[0], 32'hDA7A0010);
        chk("t1_word3", got_q[3], 32'hDA7A0013);

        // address wrap
        cyc_adv(); acc = 0; got_q.delete();
        do_start(15'h7FFE, 16'd4, s0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wrap_addrb", 32'(addrb), 32'(wrap_exp[k]));
        end
        run(50, 1'b0, lowc, dcyc);
        chk("wrap_beats", acc, 4);
        chk("wrap_word2", got_q[2], 32'hDA7A0000);

        // random backpressure
        cyc_adv(); acc = 0; got_q.delete();
        do_start(15'h1000, 16'd64, s0);
        run(2000, 1'b1, lowc, dcyc);
        dout_ready = 1'b1;
        chk("bp_beats", acc, 64);
        chk("bp_left", exp_q.size(), 0);
        chk("bp_done_lag", dcyc - last_cyc, 2);

        // zero count, with a start presented during DONE
        cyc_adv(); acc = 0;
        do_start(15'h0020, 16'd0, s0);
        start = 1'b1; base_addr = 15'h0050; word_count = 16'd3;
        run(20, 1'b0, lowc, dcyc);
        chk("zero_done_at", dcyc - s0, 2);
        chk("zero_busy_low", lowc, 1);
        repeat (8) cyc_adv();
        chk("zero_beats", acc, 0);

        // oversized count reads the whole buffer once
        cyc_adv(); acc = 0; got_q.delete();
        do_start(15'h0005, 16'd40000, s0);
        run(40000, 1'b0, lowc, dcyc);
        chk("full_beats", acc, 32768);
        chk("full_left", exp_q.size(), 0);
        got_q.delete();

        // abort after 10 beats, then a fresh readout
        cyc_adv(); acc = 0;
        do_start(15'h0000, 16'd100, s0);
        for (int k = 0; k < 300 && acc < 10; k++) cyc_adv();
        chk("abort_reach", acc, 10);
        dout_ready = 1'b0; abort = 1'b1; exp_q.delete();
        cyc_adv();
        abort = 1'b0;
        @(negedge clk);
        chk("ab_valid", 32'(dout_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("ab_done", 32'(done), 32'd1);
        cyc_adv();
        dout_ready = 1'b1;
        repeat (8) cyc_adv();
        chk("ab_no_more", acc, 10);
        acc = 0; got_q.delete();
        do_start(15'h0200, 16'd2, s0);
        run(50, 1'b0, lowc, dcyc);
        chk("ab_new_beats", acc, 2);
        chk("ab_new_w0", got_q[0], 32'hDA7A0200);
        chk("ab_new_w1", got_q[1], 32'hDA7A0201);

        // start while busy is ignored
        cyc_adv(); acc = 0;
        do_start(15'h0100, 16'd8, s0);
        cyc_adv();
        start = 1'b1; base_addr = 15'h0300; word_count = 16'd5;
        cyc_adv();
        start = 1'b0;
        run(60, 1'b0, lowc, dcyc);
        chk("sb_beats", acc, 8);
        chk("sb_left", exp_q.size(), 0);
        dh = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dh++;
        end
        chk("sb_extra_done", dh, 0);
        chk("sb_beats_after", acc, 8);

        // abort while idle does nothing
        cyc_adv();
        abort = 1'b1;
        cyc_adv();
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle_abort_done", 32'(done), 32'd0);

        // reset mid-readout
        cyc_adv(); acc = 0;
        do_start(15'h0040, 16'd50, s0);
        repeat (6) cyc_adv();
        resetn = 1'b0; dout_ready = 1'b0; exp_q.delete();
        cyc_adv();
        @(negedge clk);
        chk("mr_addrb", 32'(addrb), 32'd0);
        chk("mr_valid", 32'(dout_valid), 32'd0);
        chk("mr_last", 32'(dout_last), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        cyc_adv();
        resetn = 1'b1;
        dout_ready = 1'b1;
        dh = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || dout_valid) dh++;
        end
        chk("mr_quiet", dh, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
